// File: rtl/fifo4x16.sv
// fifo4x16: 4-entry, 16-bit synchronous show-ahead FIFO.
// Storage is four 16-bit registers; the head word is selected by a
// Mux4Way16 steered by the 2-bit read pointer.
// Optional build macro: FIFO4X16_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs.

// Mux4Way16: 4-to-1 selector of 16-bit words.
module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // Select one of the four words by sel.
  always_comb begin
    unique case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

module fifo4x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out_data,
  output logic        empty,
  output logic        full,
  output logic [2:0]  count
`ifdef FIFO4X16_ERR_FLAGS_EN
  ,
  output logic        overflow,
  output logic        underflow
`endif
);

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_word;

  // Flags come straight from the registered count, so they only change
  // after a clock edge.
  assign empty = (count_q == 3'd0);
  assign full  = (count_q == 3'(DEPTH));
  assign count = count_q;

  // A pop is accepted whenever there is data. A push is accepted when there
  // is room, or when full and a pop frees the head slot in the same cycle.
  // On empty, push+pop accepts only the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage is cleared on reset on purpose, so stale words can
      // never reappear; this makes it flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= in_data;
    end
  end

  mux4way16 u_read_mux (
    .a   (mem_q[0]),
    .b   (mem_q[1]),
    .c   (mem_q[2]),
    .d   (mem_q[3]),
    .sel (rd_ptr_q),
    .out (head_word)
  );

  // Show-ahead head word, forced to zero while the FIFO is empty.
  assign out_data = empty ? '0 : head_word;

`ifdef FIFO4X16_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; a combined push+pop never counts as an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full && !pop)  overflow_q  <= 1'b1;
      if (pop && empty && !push) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo4x16.sv
// tb_fifo4x16: directed bench for fifo4x16 with a queue-based reference
// model compared on every falling edge, plus literal spot checks.
module tb_fifo4x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        push;
  logic        pop;
  logic [15:0] out_data;
  logic        empty;
  logic        full;
  logic [2:0]  count;
`ifdef FIFO4X16_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: an ordered queue of words plus sticky flags.
  logic [15:0] model_q [$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  fifo4x16 dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .push     (push),
    .pop      (pop),
    .out_data (out_data),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef FIFO4X16_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, return on the
  // following falling edge.
  task automatic step(input bit r, input bit pu, input bit po, input logic [15:0] d);
    bit was_full, was_empty;
    reset   = r;
    push    = pu;
    pop     = po;
    in_data = d;
    @(posedge clk);
    was_full  = (model_q.size() == 4);
    was_empty = (model_q.size() == 0);
    if (r) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (pu && was_full && !po)  m_ovf = 1'b1;
      if (po && was_empty && !pu) m_unf = 1'b1;
      if (po && !was_empty) void'(model_q.pop_front());
      if (pu && (!was_full || po)) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  // Continuous comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("m_count", 32'(count), 32'(model_q.size()));
      check("m_empty", 32'(empty), 32'(model_q.size() == 0));
      check("m_full",  32'(full),  32'(model_q.size() == 4));
      check("m_out",   32'(out_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
`ifdef FIFO4X16_ERR_FLAGS_EN
      check("m_ovf", 32'(overflow),  32'(m_ovf));
      check("m_unf", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  logic [15:0] fill_v [4] = '{16'hF000, 16'h0F00, 16'h00F0, 16'h000F};

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; in_data = '0;
    @(negedge clk);

    // Reset dominates a simultaneous push.
    step(1, 1, 0, 16'hF000);
    mon_en = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_out",   32'(out_data), 32'h0);

    // Fill: count climbs 1..4, head stays F000.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, fill_v[i]);
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_head",  32'(out_data), 32'hF000);
    end
    check("fill_full", 32'(full), 32'd1);

    // Drain in order, then empty with zero output.
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(out_data), 32'(fill_v[i]));
      step(0, 0, 1, 16'h0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_out",   32'(out_data), 32'h0);

    // Refill, push while full (ignored), then push+pop while full.
    for (int i = 0; i < 4; i++) step(0, 1, 0, fill_v[i]);
    step(0, 1, 0, 16'hAAAA);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head",  32'(out_data), 32'hF000);
    step(0, 1, 1, 16'h1234);
    check("pp_full_count", 32'(count), 32'd4);
    begin
      logic [15:0] exp_order [4] = '{16'h0F00, 16'h00F0, 16'h000F, 16'h1234};
      for (int i = 0; i < 4; i++) begin
        check("pp_full_order", 32'(out_data), 32'(exp_order[i]));
        step(0, 0, 1, 16'h0);
      end
    end

    // Push+pop while empty: only the push lands.
    step(0, 1, 1, 16'h5555);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_out",   32'(out_data), 32'h5555);
    step(0, 0, 1, 16'h0);
    // Pop while empty alone: ignored (sets underflow when enabled).
    step(0, 0, 1, 16'h0);
    check("unf_count", 32'(count), 32'd0);

    // Wrap-around: pointers advance 11 times through the interleave.
    step(0, 1, 0, 16'h1000);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 16'h1001 + 16'(i));
    check("wrap_head", 32'(out_data), 32'h100A);

    // Mid-operation reset with three words stored.
    step(0, 1, 0, 16'h2001);
    step(0, 1, 0, 16'h2002);
    check("pre_rst_count", 32'(count), 32'd3);
    step(1, 0, 0, 16'h0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_out",   32'(out_data), 32'h0);
    step(0, 1, 0, 16'h000F);
    check("post_rst_out", 32'(out_data), 32'h000F);
    step(0, 0, 0, 16'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
